// File: rtl/riscv_mem_pkg.sv
// Shared types and default widths for the memory-side blocks of the core.
//
// Contents:
//   arb_state_e  - arbiter FSM states (IDLE, ISSUE, WAIT_RESP)
//   arb_owner_e  - which port owns the transaction in flight
//   *_DEF        - default parameter values used by mem_arbiter
package riscv_mem_pkg;

  localparam int ADDR_W_DEF          = 32;
  localparam int DATA_W_DEF          = 32;
  localparam int MAX_DATA_STREAK_DEF = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } arb_owner_e;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Starvation guard for mem_arbiter: counts consecutive data grants taken
// while fetch is also waiting, and flags when the run reaches the limit.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   data_win   - data port won the current arbitration
//   instr_win  - fetch port won the current arbitration
//   instr_req  - fetch request level at the arbitration edge
//   streak_max - count equals MAX_DATA_STREAK (fetch must win next contest)
module mem_arb_starve_cnt #(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic data_win,
  input  logic instr_win,
  input  logic instr_req,
  output logic streak_max
);

  localparam int CNT_W = $clog2(MAX_DATA_STREAK + 1);

  logic [CNT_W-1:0] cnt_reg;

  // Only data wins that actually made fetch wait extend the streak; the
  // count never exceeds the limit because fetch wins once it is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (instr_win || (data_win && !instr_req)) begin
      cnt_reg <= '0;
    end else if (data_win && instr_req && (cnt_reg != CNT_W'(MAX_DATA_STREAK))) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign streak_max = (cnt_reg == CNT_W'(MAX_DATA_STREAK));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one single-port RAM between instruction
// fetch and the LSU data port. One transaction is in flight at a time; the
// response is routed back to the port that issued it. Data has priority.
//
// Optional feature: define ARB_STARVE_GUARD_EN to enable the starvation
// guard (fetch wins after MAX_DATA_STREAK consecutive contested data wins).
//
// Ports:
//   req, reset                    - clock (rising edge), async active-high reset
//   instr_req_in/addr_in          - fetch request
//   instr_gnt_o/rvalid_o/rdata_o  - fetch grant and response
//   data_req_in/add_in/we_in/be_in/wdata_in - LSU request
//   data_gnt_o/rvalid_o/rdata_o   - LSU grant and response
//   mem_req_o/add_o/we_o/be_o/wdata_o       - RAM request (registered)
//   mem_gnt_in/rvalid_in/rdata_in - RAM grant and response
module mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int DATA_W          = DATA_W_DEF,
  parameter int MAX_DATA_STREAK = MAX_DATA_STREAK_DEF
) (
  input  logic                  req,
  input  logic                  reset,
  // fetch port
  input  logic                  instr_req_in,
  input  logic [ADDR_W-1:0]     instr_addr_in,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [DATA_W-1:0]     instr_rdata_o,
  // LSU port
  input  logic                  data_req_in,
  input  logic [ADDR_W-1:0]     data_add_in,
  input  logic                  data_we_in,
  input  logic [DATA_W/8-1:0]   data_be_in,
  input  logic [DATA_W-1:0]     data_wdata_in,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [DATA_W-1:0]     data_rdata_o,
  // RAM port
  output logic                  mem_req_o,
  output logic [ADDR_W-1:0]     mem_add_o,
  output logic                  mem_we_o,
  output logic [DATA_W/8-1:0]   mem_be_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic                  mem_gnt_in,
  input  logic                  mem_rvalid_in,
  input  logic [DATA_W-1:0]     mem_rdata_in
);

  localparam int BE_W = DATA_W / 8;

  arb_state_e          state_reg;
  arb_owner_e          owner_reg;
  logic [ADDR_W-1:0]   add_reg;
  logic                we_reg;
  logic [BE_W-1:0]     be_reg;
  logic [DATA_W-1:0]   wdata_reg;

  logic arb_en;
  logic data_win;
  logic instr_win;
  logic streak_max;

  // A new winner may be chosen when idle, or in the same cycle the previous
  // response returns, which gives back-to-back issue every two cycles.
  assign arb_en = (state_reg == IDLE) || ((state_reg == WAIT_RESP) && mem_rvalid_in);

`ifdef ARB_STARVE_GUARD_EN
  mem_arb_starve_cnt #(
    .MAX_DATA_STREAK (MAX_DATA_STREAK)
  ) u_starve_cnt (
    .clk        (req),
    .rst        (reset),
    .data_win   (data_win),
    .instr_win  (instr_win),
    .instr_req  (instr_req_in),
    .streak_max (streak_max)
  );
`else
  assign streak_max = 1'b0;
`endif

  assign data_win  = arb_en && data_req_in && !(instr_req_in && streak_max);
  assign instr_win = arb_en && instr_req_in && !data_win;

  always_ff @(posedge req or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      owner_reg <= OWN_NONE;
      add_reg   <= '0;
      we_reg    <= 1'b0;
      be_reg    <= '0;
      wdata_reg <= '0;
    end else begin
      if (arb_en) begin
        if (data_win) begin
          state_reg <= ISSUE;
          owner_reg <= OWN_DATA;
          add_reg   <= data_add_in;
          we_reg    <= data_we_in;
          be_reg    <= data_be_in;
          wdata_reg <= data_wdata_in;
        end else if (instr_win) begin
          // Fetch is always a full-word read.
          state_reg <= ISSUE;
          owner_reg <= OWN_INSTR;
          add_reg   <= instr_addr_in;
          we_reg    <= 1'b0;
          be_reg    <= '1;
          wdata_reg <= '0;
        end else begin
          state_reg <= IDLE;
          owner_reg <= OWN_NONE;
        end
      end else if ((state_reg == ISSUE) && mem_gnt_in) begin
        state_reg <= WAIT_RESP;
      end
    end
  end

  // RAM side is driven only from the captured request.
  assign mem_req_o   = (state_reg == ISSUE);
  assign mem_add_o   = add_reg;
  assign mem_we_o    = we_reg;
  assign mem_be_o    = be_reg;
  assign mem_wdata_o = wdata_reg;

  // Grant and response are forwarded to the owner in the same cycle; RAM
  // handshakes seen outside the matching state are dropped.
  assign instr_gnt_o    = (state_reg == ISSUE) && mem_gnt_in && (owner_reg == OWN_INSTR);
  assign data_gnt_o     = (state_reg == ISSUE) && mem_gnt_in && (owner_reg == OWN_DATA);
  assign instr_rvalid_o = (state_reg == WAIT_RESP) && mem_rvalid_in && (owner_reg == OWN_INSTR);
  assign data_rvalid_o  = (state_reg == WAIT_RESP) && mem_rvalid_in && (owner_reg == OWN_DATA);
  assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_in : '0;
  assign data_rdata_o   = data_rvalid_o  ? mem_rdata_in : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases, then a scoreboard
// phase with random requesters and a random-latency RAM model.
module tb_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int MAXS = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          instr_req_in;
  logic [AW-1:0] instr_addr_in;
  logic          instr_gnt_o, instr_rvalid_o;
  logic [DW-1:0] instr_rdata_o;
  logic          data_req_in;
  logic [AW-1:0] data_add_in;
  logic          data_we_in;
  logic [BW-1:0] data_be_in;
  logic [DW-1:0] data_wdata_in;
  logic          data_gnt_o, data_rvalid_o;
  logic [DW-1:0] data_rdata_o;
  logic          mem_req_o;
  logic [AW-1:0] mem_add_o;
  logic          mem_we_o;
  logic [BW-1:0] mem_be_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_gnt_in, mem_rvalid_in;
  logic [DW-1:0] mem_rdata_in;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_STREAK(MAXS)) dut (
    .req(clk), .reset(rst),
    .instr_req_in(instr_req_in), .instr_addr_in(instr_addr_in),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_in(data_req_in), .data_add_in(data_add_in), .data_we_in(data_we_in),
    .data_be_in(data_be_in), .data_wdata_in(data_wdata_in),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_add_o(mem_add_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_in(mem_gnt_in), .mem_rvalid_in(mem_rvalid_in), .mem_rdata_in(mem_rdata_in)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct {
    bit            is_data;
    logic [DW-1:0] rdata;
  } resp_t;

  req_t  iq[$];
  req_t  dq[$];
  resp_t rq[$];
  bit    grant_log[$];

  bit mon_en   = 1'b0;
  bit ram_auto = 1'b0;
  bit ram_fast = 1'b0;
  bit stray_en = 1'b0;
  bit req_run  = 1'b0;
  int gap_max  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // RAM behaviour: random (or immediate) grants, response 1..3 cycles after
  // acceptance, optional stray rvalid pulses while nothing is outstanding.
  task automatic ram_model();
    bit            outstanding = 1'b0;
    int            dl = 0;
    logic [DW-1:0] rd = '0;
    bit            acc, fired;
    logic [AW-1:0] acc_a;
    forever begin
      @(negedge clk);
      acc   = mem_req_o && mem_gnt_in;
      acc_a = mem_add_o;
      fired = mem_rvalid_in && outstanding;
      @(posedge clk);
      #1;
      if (!ram_auto) begin
        outstanding = 1'b0;
        continue;
      end
      if (fired) outstanding = 1'b0;
      if (acc) begin
        outstanding = 1'b1;
        rd = ram_word(acc_a);
        dl = ram_fast ? 1 : int'($urandom_range(1, 3));
      end
      mem_gnt_in = ram_fast ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (outstanding) begin
        if (dl <= 1) begin
          mem_rvalid_in = 1'b1;
          mem_rdata_in  = rd;
        end else begin
          mem_rvalid_in = 1'b0;
          mem_rdata_in  = $urandom;
          dl--;
        end
      end else begin
        mem_rvalid_in = stray_en && ($urandom_range(0, 7) == 0);
        mem_rdata_in  = $urandom;
      end
    end
  endtask

  task automatic src_instr();
    bit   own = 1'b0;
    bit   seen;
    req_t r;
    forever begin
      @(negedge clk);
      seen = own && instr_gnt_o;
      @(posedge clk);
      #1;
      if (seen) begin
        instr_req_in = 1'b0;
        own = 1'b0;
      end
      if (req_run && !own && (gap_max == 0 || $urandom_range(0, gap_max) == 0)) begin
        r.addr = $urandom & 32'hFFFF_FFFC;
        r.we = 1'b0;
        r.be = '1;
        r.wdata = '0;
        iq.push_back(r);
        own = 1'b1;
        instr_req_in  = 1'b1;
        instr_addr_in = r.addr;
      end
    end
  endtask

  task automatic src_data();
    bit   own = 1'b0;
    bit   seen;
    req_t r;
    forever begin
      @(negedge clk);
      seen = own && data_gnt_o;
      @(posedge clk);
      #1;
      if (seen) begin
        data_req_in = 1'b0;
        own = 1'b0;
      end
      if (req_run && !own && (gap_max == 0 || $urandom_range(0, gap_max) == 0)) begin
        r.addr  = $urandom & 32'hFFFF_FFFC;
        r.we    = 1'($urandom_range(0, 1));
        r.be    = BW'($urandom_range(1, 15));
        r.wdata = $urandom;
        dq.push_back(r);
        own = 1'b1;
        data_req_in   = 1'b1;
        data_add_in   = r.addr;
        data_we_in    = r.we;
        data_be_in    = r.be;
        data_wdata_in = r.wdata;
      end
    end
  endtask

  // Scoreboard monitor. Arbitration model: the winner is decided from the
  // request levels at the edge that launches the transaction; data wins
  // unless fetch also waits and the data streak has reached MAXS (guard).
  task automatic monitor();
    bit    prev_req = 1'b0, exp_start = 1'b0, pi_prev = 1'b0, pd_prev = 1'b0;
    bit    cur_is_data = 1'b0;
    int    streak = 0;
    req_t  cur;
    resp_t rsp;
    bit    pend_i, pend_d, idle_now, rv_now, new_txn, g, exp_irv, exp_drv;
    cur.addr = '0; cur.we = 1'b0; cur.be = '0; cur.wdata = '0;
    forever begin
      @(negedge clk);
      if (rst) streak = 0;
      if (!mon_en || rst) begin
        prev_req = mem_req_o;
        exp_start = 1'b0;
        continue;
      end
      pend_i   = instr_req_in;
      pend_d   = data_req_in;
      idle_now = !mem_req_o && (rq.size() == 0);
      rv_now   = mem_rvalid_in && (rq.size() > 0);
      new_txn  = mem_req_o && !prev_req;
      chk("txn_start", 64'(new_txn), 64'(exp_start));
      if (new_txn) begin
        cur_is_data = pd_prev && !(GUARD && pi_prev && streak == MAXS);
        if (cur_is_data && pi_prev) streak++;
        else streak = 0;
        chk("txn_src_queue", 64'(cur_is_data ? dq.size() > 0 : iq.size() > 0), 64'd1);
        if (cur_is_data && dq.size() > 0) cur = dq[0];
        else if (!cur_is_data && iq.size() > 0) cur = iq[0];
      end
      if (mem_req_o) begin
        chk("mem_add", 64'(mem_add_o), 64'(cur.addr));
        chk("mem_we",  64'(mem_we_o),  64'(cur.we));
        chk("mem_be",  64'(mem_be_o),  64'(cur.be));
        if (cur_is_data) chk("mem_wdata", 64'(mem_wdata_o), 64'(cur.wdata));
      end
      exp_irv = rv_now && !rq[0].is_data;
      exp_drv = rv_now && rq[0].is_data;
      chk("instr_rvalid", 64'(instr_rvalid_o), 64'(exp_irv));
      chk("data_rvalid",  64'(data_rvalid_o),  64'(exp_drv));
      chk("instr_rdata",  64'(instr_rdata_o),  exp_irv ? 64'(rq[0].rdata) : 64'd0);
      chk("data_rdata",   64'(data_rdata_o),   exp_drv ? 64'(rq[0].rdata) : 64'd0);
      if (rv_now) void'(rq.pop_front());
      g = mem_req_o && mem_gnt_in;
      chk("instr_gnt", 64'(instr_gnt_o), 64'(g && !cur_is_data));
      chk("data_gnt",  64'(data_gnt_o),  64'(g && cur_is_data));
      if (g) begin
        if (cur_is_data && dq.size() > 0) void'(dq.pop_front());
        if (!cur_is_data && iq.size() > 0) void'(iq.pop_front());
        rsp.is_data = cur_is_data;
        rsp.rdata   = ram_word(cur.addr);
        rq.push_back(rsp);
        grant_log.push_back(cur_is_data);
      end
      exp_start = (idle_now || rv_now) && (pend_i || pend_d);
      pi_prev  = pend_i;
      pd_prev  = pend_d;
      prev_req = mem_req_o;
    end
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    while ((iq.size() != 0 || dq.size() != 0 || rq.size() != 0 ||
            instr_req_in || data_req_in) && cyc < 400) begin
      tick();
      cyc++;
    end
    chk({name, "_drained"}, 64'(iq.size() + dq.size() + rq.size()), 64'd0);
  endtask

  initial begin
    int gnt_cnt;
    int cyc;
    instr_req_in = 0; instr_addr_in = '0;
    data_req_in = 0; data_add_in = '0; data_we_in = 0; data_be_in = '0; data_wdata_in = '0;
    mem_gnt_in = 0; mem_rvalid_in = 0; mem_rdata_in = '0;
    rst = 1'b1;

    fork
      ram_model();
      src_instr();
      src_data();
      monitor();
      begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", 64'(mem_req_o), 64'd0);
    chk("rst_mem_bus", 64'({mem_we_o, mem_be_o, mem_add_o}), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata_o), 64'd0);
    chk("rst_port_ctl", 64'({instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o}), 64'd0);
    chk("rst_rdata", 64'({instr_rdata_o, data_rdata_o}), 64'd0);
    tick();
    rst = 1'b0;

    // Single fetch: gnt in N+1, rvalid in N+2
    tick();
    instr_req_in = 1; instr_addr_in = 32'h10; mem_gnt_in = 1;
    @(negedge clk);
    chk("fetch_N_mem_req", 64'(mem_req_o), 64'd0);
    tick();
    @(negedge clk);
    chk("fetch_N1_mem_req", 64'(mem_req_o), 64'd1);
    chk("fetch_N1_bus", 64'({mem_we_o, mem_be_o, mem_add_o}), 64'({1'b0, 4'hF, 32'h10}));
    chk("fetch_N1_gnt", 64'({instr_gnt_o, data_gnt_o}), 64'b10);
    tick();
    instr_req_in = 0; mem_rvalid_in = 1; mem_rdata_in = 32'h0010_0093;
    @(negedge clk);
    chk("fetch_N2_rvalid", 64'({instr_rvalid_o, data_rvalid_o}), 64'b10);
    chk("fetch_N2_rdata", 64'(instr_rdata_o), 64'h0010_0093);
    chk("fetch_N2_data_rdata", 64'(data_rdata_o), 64'd0);
    tick();
    mem_rvalid_in = 0;
    @(negedge clk);
    chk("fetch_done", 64'({mem_req_o, instr_rvalid_o}), 64'd0);

    // Single write
    tick();
    data_req_in = 1; data_add_in = 32'h200; data_we_in = 1; data_be_in = 4'b0011;
    data_wdata_in = 32'hDEAD_BEEF;
    tick();
    @(negedge clk);
    chk("wr_bus", 64'({mem_req_o, mem_we_o, mem_be_o, mem_add_o}), 64'({1'b1, 1'b1, 4'b0011, 32'h200}));
    chk("wr_wdata", 64'(mem_wdata_o), 64'hDEAD_BEEF);
    chk("wr_gnt", 64'({instr_gnt_o, data_gnt_o}), 64'b01);
    tick();
    data_req_in = 0; mem_rvalid_in = 1; mem_rdata_in = 32'h0;
    @(negedge clk);
    chk("wr_rvalid", 64'({instr_rvalid_o, data_rvalid_o}), 64'b01);
    tick();
    mem_rvalid_in = 0;
    @(negedge clk);
    chk("wr_rvalid_once", 64'(data_rvalid_o), 64'd0);

    // Stalled grant: 5 cycles with mem_gnt_in low
    tick();
    mem_gnt_in = 0;
    data_req_in = 1; data_add_in = 32'h300; data_we_in = 0; data_be_in = 4'hF;
    data_wdata_in = 32'h1111_2222;
    tick();
    gnt_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall_bus_%0d", i), 64'({mem_req_o, mem_we_o, mem_be_o, mem_add_o}),
          64'({1'b1, 1'b0, 4'hF, 32'h300}));
      gnt_cnt += int'(data_gnt_o) + int'(instr_gnt_o);
      tick();
    end
    mem_gnt_in = 1;
    @(negedge clk);
    chk("stall_release_gnt", 64'(data_gnt_o), 64'd1);
    gnt_cnt += int'(data_gnt_o) + int'(instr_gnt_o);
    tick();
    data_req_in = 0; mem_rvalid_in = 1; mem_rdata_in = 32'h1234_5678;
    @(negedge clk);
    chk("stall_rdata", 64'({data_rvalid_o, data_rdata_o}), 64'({1'b1, 32'h1234_5678}));
    gnt_cnt += int'(data_gnt_o) + int'(instr_gnt_o);
    tick();
    mem_rvalid_in = 0;
    @(negedge clk);
    gnt_cnt += int'(data_gnt_o) + int'(instr_gnt_o);
    chk("stall_one_gnt", 64'(gnt_cnt), 64'd1);

    // Reset while waiting for the response, then a stray rvalid
    tick();
    data_req_in = 1; data_add_in = 32'h400; data_we_in = 1; data_be_in = 4'hF;
    data_wdata_in = 32'hCAFE_F00D; mem_gnt_in = 1;
    tick();
    tick();
    data_req_in = 0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_mem_bus", 64'({mem_req_o, mem_we_o, mem_be_o, mem_add_o}), 64'd0);
    chk("midrst_mem_wdata", 64'(mem_wdata_o), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; mem_gnt_in = 0; mem_rvalid_in = 1; mem_rdata_in = 32'hBAAD_F00D;
    @(negedge clk);
    chk("stray_rvalid", 64'({instr_rvalid_o, data_rvalid_o}), 64'd0);
    chk("stray_rdata", 64'({instr_rdata_o, data_rdata_o}), 64'd0);
    chk("stray_mem_req", 64'(mem_req_o), 64'd0);
    tick();
    mem_rvalid_in = 0;

    // Continuous requests from both ports, immediate RAM
    grant_log.delete();
    ram_fast = 1; stray_en = 0; ram_auto = 1; mon_en = 1; gap_max = 0;
    tick();
    req_run = 1;
    cyc = 0;
    while (grant_log.size() < 10 && cyc < 300) begin
      tick();
      cyc++;
    end
    chk("cont_ten_grants", 64'(grant_log.size() >= 10), 64'd1);
    for (int k = 0; k < 10 && k < grant_log.size(); k++) begin
      chk($sformatf("cont_order_%0d", k), 64'(grant_log[k]),
          64'(GUARD ? (k % 5 != 4) : 1'b1));
    end
    req_run = 0;
    drain("cont");

    // Random traffic with stalls, variable latency and stray rvalids
    ram_fast = 0; stray_en = 1; gap_max = 3;
    tick();
    req_run = 1;
    repeat (1500) tick();
    req_run = 0;
    drain("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one single-port unified RAM between the fetch instruction port and the LSU data port of the RISC-V core. It owns the RAM-side request/grant/valid handshake, issues one transaction at a time, and routes each response back to the port that issued it. Data accesses have priority. An optional starvation guard stops the data port from blocking fetch indefinitely.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte enables are DATA_W/8
- MAX_DATA_STREAK, 4, maximum consecutive data grants while fetch waits (guard only)

Ports:
- req  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- instr_req_in  in  1  fetch request
- instr_addr_in  in  ADDR_W  fetch address
- instr_gnt_o  out  1  fetch request accepted by RAM
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  DATA_W  fetched word
- data_req_in  in  1  LSU request
- data_add_in  in  ADDR_W  LSU address
- data_we_in  in  1  LSU write enable
- data_be_in  in  DATA_W/8  LSU byte enables
- data_wdata_in  in  DATA_W  LSU write data
- data_gnt_o  out  1  LSU request accepted by RAM
- data_rvalid_o  out  1  LSU response valid
- data_rdata_o  out  DATA_W  LSU read data
- mem_req_o  out  1  RAM request
- mem_add_o  out  ADDR_W  RAM address
- mem_we_o  out  1  RAM write enable
- mem_be_o  out  DATA_W/8  RAM byte enables
- mem_wdata_o  out  DATA_W  RAM write data
- mem_gnt_in  in  1  RAM accepted the request
- mem_rvalid_in  in  1  RAM response valid, one per accepted request, including writes
- mem_rdata_in  in  DATA_W  RAM read data

## Operation
- The FSM has three states.
  - IDLE: no request is active.
  - ISSUE: mem_req_o is high and the block waits for mem_gnt_in.
  - WAIT_RESP: the block waits for mem_rvalid_in.
- Arbitration happens in IDLE, and in WAIT_RESP during the cycle mem_rvalid_in is high.
  - Only data_req_in high: data wins.
  - Only instr_req_in high: instr wins.
  - Both high: data wins, unless the guard overrides (see Configuration).
  - Neither high: go to IDLE.
- At the arbitration edge the winner's address, we, be and wdata are captured into registers, and the owner field is set.
  - An instr winner captures we=0 and be=all ones.
  - mem_* outputs come only from these registers.
- ISSUE with mem_gnt_in high: the owner's gnt output is high combinationally in that cycle; the next state is WAIT_RESP.
- WAIT_RESP with mem_rvalid_in high: the owner's rvalid output is high combinationally, and its rdata output equals mem_rdata_in.
- The non-owner's gnt and rvalid are always 0.
- rdata outputs are 0 whenever the matching rvalid is 0.
- mem_rvalid_in in IDLE or ISSUE is ignored and never forwarded. mem_gnt_in outside ISSUE is ignored.
- Requesters hold req high until they see their gnt. A req dropped after capture still completes with the captured values.

## Timing
- Reset values: state IDLE, owner NONE, streak counter 0, every output 0.
- Reset asserted mid-transaction: everything returns to reset values at once. A late mem_rvalid_in after release is dropped.
- Latency, with the RAM granting immediately and responding one cycle later:
  - req seen in cycle N
  - mem_req_o high in N+1; gnt to the owner in N+1
  - rvalid to the owner in N+2
- Back-to-back: when both ports keep requesting, the next ISSUE starts the cycle after rvalid. Throughput is one transaction per 2 cycles.
- A stalled grant holds ISSUE with mem_* stable for any number of cycles.

## Configuration
- Macro ARB_STARVE_GUARD_EN.
- Defined:
  - A streak counter of width $clog2(MAX_DATA_STREAK+1) increments on each data win while instr_req_in is high.
  - It clears on an instr win, or on a data win with instr_req_in low.
  - With both requests high and the counter equal to MAX_DATA_STREAK, instr wins.
- Undefined: strict data priority, and no counter exists.

## Structure
- Shared package riscv_mem_pkg holds:
  - enum arb_state_e {IDLE, ISSUE, WAIT_RESP}
  - enum arb_owner_e {OWN_NONE, OWN_INSTR, OWN_DATA}
  - default width constants
- One sub-module, mem_arb_starve_cnt: the guard counter with its saturation compare. It is instantiated only under ARB_STARVE_GUARD_EN.

## Test plan
- Single fetch: instr_req_in=1, addr=0x10, RAM returns 0x00100093. Required: instr_gnt_o in N+1, instr_rvalid_o and rdata=0x00100093 in N+2, data port silent.
- Single write: data_add_in=0x200, we=1, be=4'b0011, wdata=0xDEADBEEF. Required: mem_add_o=0x200, mem_be_o=4'b0011, mem_wdata_o=0xDEADBEEF, data_rvalid_o once.
- Simultaneous requests in IDLE. Required: data granted first, instr second, two responses routed correctly.
- Both ports requesting continuously, guard on, MAX_DATA_STREAK=4. Required: grant order D D D D I D D D D I. With the guard off: instr is never granted.
- RAM holds mem_gnt_in low for 5 cycles. Required: mem_* stable throughout, one gnt only.
- Reset pulse in WAIT_RESP, then a stray mem_rvalid_in. Required: all outputs 0 and no rvalid forwarded.
